// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// slave = arbiter side, master = requester side.
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    modport slave (
        input  req,
        output grant, grant_idx, grant_valid, timeout
    );

    modport master (
        output req,
        input  grant, grant_idx, grant_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// 4-way round-robin arbiter driving the 2:4 decoder sequencer (grant_idx / grant_valid).
// Optional hold-limit revocation is built when RR_TIMEOUT_EN is defined.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_4_if.slave bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_arbiter_4: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {IDLE, BUSY} state_e;

    state_e     state_q;
    logic [1:0] ptr_q;
    logic [1:0] idx_q;
    logic       vld_q;
    logic [3:0] grant_q;

    logic [3:0] rot;
    logic [1:0] off;
    logic       sel_hit;
    logic [1:0] sel_d;
    logic       own_req;

    // Rotate so bit 0 is the current highest-priority requester, then pick the lowest set bit.
    always_comb begin
        rot     = 4'({bus.req, bus.req} >> ptr_q);
        off     = 2'd0;
        sel_hit = 1'b1;
        if      (rot[0]) off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
        else             sel_hit = 1'b0;
        sel_d   = ptr_q + off;
    end

    assign own_req = bus.req[idx_q];

`ifdef RR_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q;
    logic       timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            idx_q      <= 2'd0;
            vld_q      <= 1'b0;
            grant_q    <= 4'd0;
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_hit) begin
                        state_q    <= BUSY;
                        idx_q      <= sel_d;
                        vld_q      <= 1'b1;
                        grant_q    <= 4'b0001 << sel_d;
                        ptr_q      <= sel_d + 2'd1;
                        hold_cnt_q <= 8'd0;
                    end
                end
                BUSY: begin
                    // A voluntary release on the limit edge wins, so no timeout pulse then.
                    if (!own_req) begin
                        state_q <= IDLE;
                        idx_q   <= 2'd0;
                        vld_q   <= 1'b0;
                        grant_q <= 4'd0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q   <= IDLE;
                        idx_q     <= 2'd0;
                        vld_q     <= 1'b0;
                        grant_q   <= 4'd0;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.timeout = timeout_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            vld_q   <= 1'b0;
            grant_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_hit) begin
                        state_q <= BUSY;
                        idx_q   <= sel_d;
                        vld_q   <= 1'b1;
                        grant_q <= 4'b0001 << sel_d;
                        ptr_q   <= sel_d + 2'd1;
                    end
                end
                BUSY: begin
                    // Dropping to IDLE forces one dead cycle before the next owner.
                    if (!own_req) begin
                        state_q <= IDLE;
                        idx_q   <= 2'd0;
                        vld_q   <= 1'b0;
                        grant_q <= 4'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.timeout = 1'b0;
`endif

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = vld_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed + random check of rr_arbiter_4 against an owner/priority model.
module tb_rr_arbiter_4;
    localparam int MAXH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_arbiter_4_if bus();
    rr_arbiter_4 #(.MAX_HOLD(MAXH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errs   = 0;

    // Model: who owns the resource (-1 none), who gets first look next, cycles held.
    int   m_owner, m_next, m_hold;
    logic m_to;

    task automatic m_reset();
        m_owner = -1; m_next = 0; m_hold = 0; m_to = 1'b0;
    endtask

    task automatic m_step();
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_next + k) % 4;
                if (bus.req[i] && m_owner < 0) begin
                    m_owner = i; m_next = (i + 1) % 4; m_hold = 0;
                end
            end
        end else if (!bus.req[m_owner]) begin
            m_owner = -1;
        end
`ifdef RR_TIMEOUT_EN
        else if (m_hold == MAXH - 1) begin
            m_owner = -1; m_to = 1'b1;
        end else begin
            m_hold++;
        end
`endif
    endtask

    task automatic chk(input string tag);
        logic [3:0] eg;
        logic [1:0] ei;
        logic       ev;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        ei = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        ev = (m_owner >= 0);
        checks++;
        assert (bus.grant === eg) else begin
            errs++; $error("FAIL %s grant got %b exp %b", tag, bus.grant, eg);
        end
        checks++;
        assert (bus.grant_idx === ei) else begin
            errs++; $error("FAIL %s grant_idx got %0d exp %0d", tag, bus.grant_idx, ei);
        end
        checks++;
        assert (bus.grant_valid === ev) else begin
            errs++; $error("FAIL %s grant_valid got %b exp %b", tag, bus.grant_valid, ev);
        end
        checks++;
        assert (bus.timeout === m_to) else begin
            errs++; $error("FAIL %s timeout got %b exp %b", tag, bus.timeout, m_to);
        end
    endtask

    task automatic tick(input string tag);
        m_step();
        @(posedge clk);
        #1;
        chk(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        m_reset();
        #1 chk("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no requests
        repeat (5) tick("idle");

        // Single requester 2, then release
        bus.req = 4'b0100;
        tick("req2_grant");
        checks++;
        assert (bus.grant === 4'b0100) else begin
            errs++; $error("FAIL req2_direct grant got %b exp 0100", bus.grant);
        end
        bus.req = 4'b0000;
        tick("req2_release");

        // All four requesting from ptr=0: order 0,1,2,3,0 with idle gaps
        rst_n = 1'b0; #1 m_reset(); chk("rst_before_rr");
        @(negedge clk); rst_n = 1'b1;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick("rr_grant");
            checks++;
            assert (bus.grant_idx === 2'(k % 4)) else begin
                errs++; $error("FAIL rr_order got %0d exp %0d", bus.grant_idx, k % 4);
            end
            tick("rr_hold");
            tick("rr_hold");
            bus.req = 4'b1111 & ~(4'b0001 << (k % 4));
            tick("rr_gap");
            bus.req = 4'b1111;
        end

        // No preemption: owner 1 keeps grant while 3 waits
        bus.req = 4'b0000;
        tick("np_idle");
        bus.req = 4'b0010;
        tick("np_grant1");
        bus.req = 4'b1010;
        tick("np_hold");
        tick("np_hold");
        bus.req = 4'b1000;
        tick("np_release");
        tick("np_grant3");

        // Persistent pair: hold-limit behaviour depends on build
        bus.req = 4'b0000;
        tick("to_idle");
        bus.req = 4'b0011;
        repeat (14) tick("to_hold");

        // Async reset mid-grant, then ptr restarts at 0
        bus.req = 4'b0000;
        tick("ar_idle");
        tick("ar_idle");
        bus.req = 4'b1000;
        tick("ar_grant3");
        #2 rst_n = 1'b0;
        #1 m_reset();
        chk("ar_async_clear");
        bus.req = 4'b1001;
        @(negedge clk); rst_n = 1'b1;
        tick("ar_after");
        checks++;
        assert (bus.grant === 4'b0001) else begin
            errs++; $error("FAIL ar_ptr0 grant got %b exp 0001", bus.grant);
        end

        // Random traffic; owners usually keep requesting
        for (int n = 0; n < 600; n++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            if (m_owner >= 0 && ($urandom_range(0, 3) != 0)) r[m_owner] = 1'b1;
            bus.req = r;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
